systolic_output_collector: RTL
==============================

Name: systolic_output_collector

Overview:
- Downstream of the weight-stationary matmul control FSM; consumes the systolic array's bottom-row outputs plus the per-column valid vector.
- Undoes the column skew by capturing each column's stream of ROWS words into a ROWS x COLS result buffer.
- Once the full result matrix is held, it streams it out one row per handshake, row 0 first, over a valid/ready interface to the writeback/BIST-compare stage.

Parameters:
WORD_SIZE, 16, width of one result word
ROWS, `ROWS, systolic rows = result rows (>=2)
COLS, `COLS, systolic columns = result columns (>=2)

Ports:
clk  input  1  system clock, all state on posedge
rst  input  1  asynchronous reset, active-low (asserted at 0)
start  input  1  one-cycle pulse; arms a new collection
sample_en  input  1  one pulse per matmul cycle from the matmul FSM; qualifies captures
matmul_output  input  COLS*WORD_SIZE  bottom_out of systolic; column c at [c*WORD_SIZE +: WORD_SIZE]
output_col_valid  input  COLS  bit c = column c's bottom_out is valid
row_data  output  COLS*WORD_SIZE  one result row, same column packing
row_idx  output  clog2(ROWS)  index of the row on row_data
row_valid  output  1  row_data/row_idx valid
row_ready  input  1  consumer accepts the row
busy  output  1  high in COLLECT or DRAIN
done  output  1  one-cycle pulse after the last row handshake
overflow  output  1  sticky error flag; cleared only by reset or start

Behaviour:
- Reset values (async, rst=0): state=IDLE, row_valid=0, row_idx=0, row_data=0, busy=0, done=0, overflow=0, all column counters=0. Buffer contents are not reset.
- States: IDLE, COLLECT, DRAIN.
  - IDLE: on start, go to COLLECT. Clear column counters and overflow.
  - COLLECT: capture event for column c = sample_en & output_col_valid[c] & cnt[c]<ROWS. On a capture event, write buf[cnt[c]][c] = matmul_output word c, then cnt[c]++.
  - COLLECT overflow: if sample_en & output_col_valid[c] & cnt[c]==ROWS, set overflow and drop the word.
  - COLLECT exit: when every cnt[c]==ROWS (including captures made this cycle), go to DRAIN next cycle with row_idx=0.
  - DRAIN: row_valid=1 and row_data=buf[row_idx], both registered. On row_valid&row_ready:
    - if row_idx<ROWS-1, row_idx++ and load the next row next cycle;
    - if row_idx==ROWS-1, row_valid drops to 0, done pulses for 1 cycle, state goes to IDLE.
  - DRAIN stall: with row_ready=0, row_data and row_idx hold stable.
- Latency: the first row_valid rises exactly 1 cycle after the clock edge that captures the final word. There is no bubble between rows while row_ready stays 1, so the drain takes ROWS cycles minimum.
- Columns are independent. Capture order within a column defines the row number, so any skew between columns (column c lags c matmul cycles) is tolerated.
- Words with sample_en=0 are ignored, even if the column is valid. This covers the second clk of a double-buffered matmul cycle.
- Valid outside COLLECT: output_col_valid & sample_en in IDLE or DRAIN sets overflow, and the data is ignored.
- start outside IDLE: ignored; no abort.
- Reset mid-operation: returns to IDLE immediately. row_valid drops asynchronously.
- Simultaneous final capture and sample on a full column: the capture completes, overflow sets, and the state still moves to DRAIN.
- Widths: counters are clog2(ROWS)+1 bits. No arithmetic on data; words pass through unmodified.

Decomposition:
- Shared package systolic_pkg:
  - collector state enum (IDLE, COLLECT, DRAIN);
  - localparams for counter width (clog2(ROWS)+1) and row index width;
  - the column-slice helper width COLS*WORD_SIZE.
- One sub-module, collector_col_buffer: a per-column ROWS-deep write-indexed register column with its own counter and full flag. Instantiate COLS times with generate; the top holds the FSM and the row mux.

Test Plan:
1. ROWS=COLS=2, start, then staircase feed with sample_en every 2nd cycle. Col0 gets 5 then 7 at samples 1,2; col1 gets 6 then 8 at samples 2,3. row_ready=1 → row0={6,5}, row1={8,7} on consecutive cycles. row_valid rises 1 cycle after the sample-3 edge. done pulses once and overflow stays 0.
2. Same as 1 but output_col_valid held high during non-sample cycles with different data (0xDEAD) → no 0xDEAD captured; results identical to 1.
3. ROWS=COLS=4, identity weights, left rows 1..16 skewed. row_ready toggles 1,0,1,0 → rows emitted in order 0..3, each held while ready=0. 4 handshakes total, then done.
4. After collection completes, a 5th sample with col0 valid → overflow=1 and buffer unchanged. The next start clears overflow to 0.
5. Assert rst=0 mid-COLLECT (2 of 4 words captured) → row_valid, busy and done are 0 immediately. A new start plus a full feed yields correct fresh results, with no stale counts.
6. Pulse start during DRAIN → ignored: remaining rows are still delivered and done pulses once.

Source files
------------

// File: rtl/systolic_output_collector_pkg.sv
// Shared types and sizing helpers for the systolic output collector.
// Array dimensions default from `ROWS/`COLS when the build defines them.
`ifndef ROWS
`define ROWS 4
`endif
`ifndef COLS
`define COLS 4
`endif

package systolic_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_DRAIN
  } collector_state_e;

  localparam int DEFAULT_WORD_SIZE = 16;
  localparam int DEFAULT_ROWS      = `ROWS;
  localparam int DEFAULT_COLS      = `COLS;

  // Column counters must represent ROWS itself, hence one extra bit.
  function automatic int cnt_width(input int rows);
    return $clog2(rows) + 1;
  endfunction

  function automatic int idx_width(input int rows);
    return (rows > 1) ? $clog2(rows) : 1;
  endfunction

  function automatic int slice_width(input int cols, input int word);
    return cols * word;
  endfunction

endpackage

// File: rtl/systolic_output_collector_col_buffer.sv
// One result column: ROWS words written in arrival order, with a fill
// counter that also detects words arriving after the column is full.
module collector_col_buffer
  import systolic_pkg::*;
#(
  parameter int WORD_SIZE = DEFAULT_WORD_SIZE,
  parameter int ROWS      = DEFAULT_ROWS,
  localparam int CW       = cnt_width(ROWS),
  localparam int IW       = idx_width(ROWS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear_i,
  input  logic                 sample_i,
  input  logic                 collect_i,
  input  logic [WORD_SIZE-1:0] wr_data_i,
  input  logic [IW-1:0]        rd_idx_i,
  output logic [WORD_SIZE-1:0] rd_data_o,
  output logic                 full_next_o,
  output logic                 drop_o
);

  logic [WORD_SIZE-1:0] mem_q [ROWS];
  logic [CW-1:0]        cnt_q;
  logic [CW-1:0]        cnt_d;
  logic                 full;
  logic                 capture;

  assign full    = (cnt_q == CW'(ROWS));
  assign capture = collect_i & sample_i & ~full;
  // Anything sampled while not collecting, or into a full column, is dropped.
  assign drop_o  = sample_i & (~collect_i | full);

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (capture) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign full_next_o = (cnt_d == CW'(ROWS));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (capture) begin
      mem_q[cnt_q[IW-1:0]] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_idx_i];

endmodule

// File: rtl/systolic_output_collector.sv
// De-skews the systolic bottom-row stream into a ROWS x COLS buffer and
// then drains it one row per valid/ready handshake, row 0 first.
module systolic_output_collector
  import systolic_pkg::*;
#(
  parameter int WORD_SIZE = DEFAULT_WORD_SIZE,
  parameter int ROWS      = DEFAULT_ROWS,
  parameter int COLS      = DEFAULT_COLS,
  localparam int IW       = idx_width(ROWS),
  localparam int DW       = slice_width(COLS, WORD_SIZE)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            sample_en,
  input  logic [DW-1:0]   matmul_output,
  input  logic [COLS-1:0] output_col_valid,
  output logic [DW-1:0]   row_data,
  output logic [IW-1:0]   row_idx,
  output logic            row_valid,
  input  logic            row_ready,
  output logic            busy,
  output logic            done,
  output logic            overflow
);

  collector_state_e state_q;
  logic [IW-1:0]    row_idx_q;
  logic [IW-1:0]    rd_idx_d;
  logic [DW-1:0]    row_data_q;
  logic             row_valid_q;
  logic             done_q;
  logic             overflow_q;

  logic [COLS-1:0]  full_next;
  logic [COLS-1:0]  drop;
  logic [DW-1:0]    rd_row;
  logic             clear;
  logic             collect;
  logic             last_row;

  assign clear    = (state_q == ST_IDLE) & start;
  assign collect  = (state_q == ST_COLLECT);
  assign last_row = (row_idx_q == IW'(ROWS - 1));

  // Look ahead one row on an accepted handshake so rows stream back to back.
  always_comb begin
    rd_idx_d = row_idx_q;
    if (row_valid_q && row_ready && !last_row) begin
      rd_idx_d = row_idx_q + 1'b1;
    end
  end

  generate
    for (genvar gi = 0; gi < COLS; gi++) begin : g_col
      collector_col_buffer #(
        .WORD_SIZE (WORD_SIZE),
        .ROWS      (ROWS)
      ) u_col (
        .clk         (clk),
        .rst         (rst),
        .clear_i     (clear),
        .sample_i    (sample_en & output_col_valid[gi]),
        .collect_i   (collect),
        .wr_data_i   (matmul_output[gi*WORD_SIZE +: WORD_SIZE]),
        .rd_idx_i    (rd_idx_d),
        .rd_data_o   (rd_row[gi*WORD_SIZE +: WORD_SIZE]),
        .full_next_o (full_next[gi]),
        .drop_o      (drop[gi])
      );
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      row_idx_q   <= '0;
      row_data_q  <= '0;
      row_valid_q <= 1'b0;
      done_q      <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (clear) begin
        overflow_q <= 1'b0;
      end else if (|drop) begin
        overflow_q <= 1'b1;
      end

      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q <= ST_COLLECT;
          end
        end
        ST_COLLECT: begin
          if (&full_next) begin
            state_q   <= ST_DRAIN;
            row_idx_q <= '0;
          end
        end
        ST_DRAIN: begin
          if (!row_valid_q) begin
            row_valid_q <= 1'b1;
            row_data_q  <= rd_row;
          end else if (row_ready) begin
            if (last_row) begin
              row_valid_q <= 1'b0;
              done_q      <= 1'b1;
              state_q     <= ST_IDLE;
            end else begin
              row_idx_q  <= rd_idx_d;
              row_data_q <= rd_row;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign row_data  = row_data_q;
  assign row_idx   = row_idx_q;
  assign row_valid = row_valid_q;
  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;
  assign overflow  = overflow_q;

endmodule
